uop_engine: RTL and testbench

- Microcode sequencer that executes one curve microprogram, e.g. the projective-to-affine conversion or doubling program, out of a synchronous micro-op ROM.
- Sits directly downstream of the ROM: drives its address, decodes each returned 20-bit word, and evaluates the execution condition against the compare flag.
- Issues single-cycle commands to the modular-arithmetic datapath and waits for completion.
- Reports overall completion to the curve-level controller via a ready/enable handshake.

---
 rtl/uop_engine_if.sv | 31 +++
 rtl/uop_engine.sv | 161 ++++++++++++++++
 tb/tb_uop_engine.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uop_engine_if.sv
// uop_engine_if: ROM, datapath and controller signals of the micro-op engine.
// master = engine side, slave = ROM/datapath/controller side.
interface uop_engine_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 20
);
  logic              ena;
  logic              rdy;
  logic [ADDR_W-1:0] uop_addr;
  logic [WORD_W-1:0] uop_data;
  logic              op_ena;
  logic [3:0]        op_opcode;
  logic [4:0]        op_src_a;
  logic [4:0]        op_src_b;
  logic [3:0]        op_dst;
  logic              op_rdy;
  logic              cmp_eq;
  logic              err;

  modport master (
    input  ena, uop_data, op_rdy, cmp_eq,
    output rdy, uop_addr, op_ena, op_opcode,
    output op_src_a, op_src_b, op_dst, err
  );

  modport slave (
    output ena, uop_data, op_rdy, cmp_eq,
    input  rdy, uop_addr, op_ena, op_opcode,
    input  op_src_a, op_src_b, op_dst, err
  );
endinterface

// File: rtl/uop_engine.sv
// uop_engine: sequences one microprogram from a sync ROM into the datapath.
// Define UOP_ENGINE_WATCHDOG_EN to bound WAIT by WDOG_CYCLES (raises err).
module uop_engine #(
  parameter int ADDR_W      = 6,
  parameter int WORD_W      = 20,
  parameter int WDOG_CYCLES = 4096
) (
  input logic          clk,
  input logic          rst_n,
  uop_engine_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  localparam logic [3:0] OP_RDY = 4'd0;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd5;

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_flag;
  logic [3:0]        r_opc;
  logic [4:0]        r_src_a;
  logic [4:0]        r_src_b;
  logic [3:0]        r_dst;
  logic [WORD_W-1:0] w_word;
  logic [3:0]        w_opc;
  logic              w_is_rdy;
  logic              w_cond;
  logic              w_last;
  logic              w_timeout;
  logic              w_rdy;
  logic              w_op_ena;

  assign w_word   = bus.uop_data;
  assign w_opc    = w_word[19:16];
  assign w_is_rdy = (w_opc == OP_RDY) || (w_opc > OP_MUL);
  assign w_last   = (r_pc == '1);

  always_comb begin
    w_cond = 1'b0;
    unique case (w_word[1:0])
      2'b00:   w_cond = 1'b1;
      2'b01:   w_cond = r_flag;
      2'b10:   w_cond = !r_flag;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.ena) w_nxt = S_FETCH;
      S_FETCH:  w_nxt = S_DECODE;
      S_DECODE: begin
        if (w_is_rdy)    w_nxt = S_DONE;
        else if (w_cond) w_nxt = S_ISSUE;
        else             w_nxt = w_last ? S_DONE : S_FETCH;
      end
      S_ISSUE:  w_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.op_rdy)     w_nxt = w_last ? S_DONE : S_FETCH;
        else if (w_timeout) w_nxt = S_DONE;
      end
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdy    = 1'b0;
    w_op_ena = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: w_rdy    = 1'b1;
      S_ISSUE:        w_op_ena = 1'b1;
      default:        ;
    endcase
  end

  // The last ROM address terminates instead of wrapping pc to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_flag  <= 1'b0;
      r_opc   <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.ena) begin
            r_pc   <= '0;
            r_flag <= 1'b0;
          end
        end
        S_DECODE: begin
          r_opc   <= w_opc;
          r_src_a <= w_word[15:11];
          r_src_b <= w_word[10:6];
          r_dst   <= w_word[5:2];
          if (!w_is_rdy && !w_cond && !w_last)
            r_pc <= r_pc + ADDR_W'(1);
        end
        S_WAIT: begin
          if (bus.op_rdy) begin
            if (r_opc == OP_CMP) r_flag <= bus.cmp_eq;
            if (!w_last)         r_pc   <= r_pc + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UOP_ENGINE_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  assign w_timeout = !bus.op_rdy &&
                     (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.ena) r_err <= 1'b0;
      if (r_state == S_ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT) begin
        r_wdog <= r_wdog + WD_W'(1);
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  // Always 0; WDOG_CYCLES only matters with the watchdog built in.
  assign bus.err   = (WDOG_CYCLES < 0);
`endif

  assign bus.rdy       = w_rdy;
  assign bus.op_ena    = w_op_ena;
  assign bus.uop_addr  = r_pc;
  assign bus.op_opcode = r_opc;
  assign bus.op_src_a  = r_src_a;
  assign bus.op_src_b  = r_src_b;
  assign bus.op_dst    = r_dst;
endmodule

// File: tb/tb_uop_engine.sv
// tb_uop_engine: table vectors, corner sequences and random ROMs
// checked against a cost/trace model of the microprogram.
module tb_uop_engine;
  localparam int AW = 6;
  localparam int WW = 20;
  localparam logic [3:0] OP_RDY = 4'd0, OP_MOV = 4'd1, OP_CMP = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [1:0] EX_AL = 2'd0, EX_EQ = 2'd1, EX_NE = 2'd2;
  localparam logic [1:0] EX_NV = 2'd3;
  localparam logic [4:0] R_ZERO = 5'd31, R_PX = 5'd1, R_PY = 5'd2;
  localparam logic [4:0] R_PZ = 5'd3, R_T0 = 5'd4;
  localparam logic [3:0] D_RX = 4'd1, D_RY = 4'd2, D_T0 = 4'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uop_engine_if #(.ADDR_W(AW), .WORD_W(WW)) bus();

  uop_engine #(
    .ADDR_W(AW), .WORD_W(WW), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [19:0] rom [64];
  always @(posedge clk) bus.uop_data <= rom[bus.uop_addr];

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_seq [64];
  int cmp_k = 0;
  int lat = 1;
  bit spur = 1'b0;
  bit mute = 1'b0;
  int stab_bad = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  typedef struct {
    string nm;
    int    prog;
    bit    cmpv;
    int    lat;
    bit    spur;
    int    ops;
    int    cyc;
    int    end_addr;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [19:0] uw(input logic [3:0] op,
    input logic [4:0] a, input logic [4:0] b,
    input logic [3:0] d, input logic [1:0] ex);
    return {op, a, b, d, ex};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int a = 0; a < 64; a++) rom[a] = 20'h0;
    case (p)
      0, 3: begin
        rom[0] = uw(OP_CMP, R_PZ, R_ZERO, 4'd0, EX_AL);
        rom[1] = uw(OP_MOV, R_PZ, 5'd0, D_T0, EX_AL);
        rom[2] = uw(OP_MUL, R_T0, R_T0, D_T0, EX_AL);
        rom[3] = uw(OP_MUL, R_PX, R_T0, D_RX, EX_AL);
        rom[4] = uw(OP_MUL, R_T0, R_PZ, D_T0, EX_AL);
        rom[5] = uw(OP_MUL, R_PY, R_T0, D_RY, EX_AL);
        rom[6] = uw(OP_MOV, R_ZERO, 5'd0, D_RX, EX_EQ);
        rom[7] = uw(OP_MOV, R_ZERO, 5'd0, D_RY, EX_EQ);
        rom[8] = uw(OP_RDY, 5'd0, 5'd0, 4'd0, EX_AL);
        if (p == 3) begin
          rom[0] = uw(OP_MOV, R_PX, 5'd0, D_RX, EX_EQ);
          rom[1] = uw(OP_MOV, R_PY, 5'd0, D_RY, EX_NE);
          rom[2] = uw(OP_RDY, 5'd0, 5'd0, 4'd0, EX_AL);
        end
      end
      1: for (int a = 0; a < 64; a++)
           rom[a] = uw(OP_MOV, 5'(a), 5'd0, 4'(a), EX_AL);
      default: for (int a = 0; a < 64; a++)
           rom[a] = uw(OP_MUL, 5'(a), 5'd1, 4'd0, EX_NV);
    endcase
  endtask

  // Reference: walk the program, accumulating cycle cost per rule.
  task automatic model(input int l, output int cyc);
    int pc, k, op;
    bit flag, go;
    logic [19:0] w;
    pc = 0; k = 0; flag = 1'b0; cyc = 0;
    exp_q.delete();
    forever begin
      w  = rom[pc];
      op = int'(w[19:16]);
      if (op == 0 || op > 5) begin
        cyc += 2;
        break;
      end
      go = (w[1:0] == EX_AL) || (w[1:0] == EX_EQ && flag) ||
           (w[1:0] == EX_NE && !flag);
      if (go) begin
        exp_q.push_back(w[19:2]);
        cyc += 3 + l;
        if (op == 2) begin
          flag = cmp_seq[k];
          k++;
        end
      end else begin
        cyc += 2;
      end
      if (pc == 63) break;
      pc++;
    end
    cyc += 1;
  endtask

  // Datapath stand-in: records issues, answers after lat cycles.
  initial begin
    logic [17:0] cap;
    bus.op_rdy = 1'b0;
    bus.cmp_eq = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.op_ena && rst_n) begin
        cap = {bus.op_opcode, bus.op_src_a, bus.op_src_b, bus.op_dst};
        got_q.push_back(cap);
        if (!mute) begin
          for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            if (bus.op_ena || cap !== {bus.op_opcode, bus.op_src_a,
                                       bus.op_src_b, bus.op_dst})
              stab_bad++;
          end
          bus.op_rdy = 1'b1;
          if (cap[17:14] == OP_CMP) begin
            bus.cmp_eq = cmp_seq[cmp_k];
            cmp_k++;
          end else begin
            bus.cmp_eq = 1'($urandom);
          end
          @(posedge clk); #1;
          if (spur) begin
            bus.cmp_eq = ~bus.cmp_eq;
            @(posedge clk); #1;
          end
          bus.op_rdy = 1'b0;
        end
      end
    end
  end

  task automatic start_prog();
    @(posedge clk); #1;
    bus.ena = 1'b1;
    @(posedge clk); #1;
    bus.ena = 1'b0;
  endtask

  task automatic run(input string nm, input int e_ops, input int e_cyc);
    int c, mcyc;
    model(lat, mcyc);
    got_q.delete();
    stab_bad = 0;
    cmp_k = 0;
    start_prog();
    c = 1;
    while (!bus.rdy && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk({nm, " cycles"}, c, mcyc);
    if (e_cyc >= 0) chk({nm, " spec cycles"}, c, e_cyc);
    chk({nm, " n_ops"}, got_q.size(), exp_q.size());
    if (e_ops >= 0) chk({nm, " spec n_ops"}, got_q.size(), e_ops);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s op%0d", nm, i), got_q[i], exp_q[i]);
    chk({nm, " op stable"}, stab_bad, 0);
    chk({nm, " err"}, bus.err, 1'b0);
  endtask

  initial begin
    int c, r;
    logic [3:0] op;
    bus.ena = 1'b0;
    vecs[0] = '{"conv_ne", 0, 1'b0, 1, 1'b0, 6, 31, 8};
    vecs[1] = '{"conv_eq", 0, 1'b1, 1, 1'b0, 8, 35, 8};
    vecs[2] = '{"conv_slow", 0, 1'b0, 10, 1'b1, 6, 85, 8};
    vecs[3] = '{"all_mov", 1, 1'b0, 1, 1'b0, 64, 257, 63};
    vecs[4] = '{"all_never", 2, 1'b0, 1, 1'b0, 0, 129, 63};
    vecs[5] = '{"flag_probe", 3, 1'b0, 1, 1'b0, 1, 9, 2};
    load_prog(0);

    #1;
    chk("reset rdy", bus.rdy, 1'b1);
    chk("reset op_ena", bus.op_ena, 1'b0);
    chk("reset uop_addr", bus.uop_addr, 0);
    chk("reset op fields", {bus.op_opcode, bus.op_src_a,
        bus.op_src_b, bus.op_dst}, 0);
    chk("reset err", bus.err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[v]) begin
      load_prog(vecs[v].prog);
      foreach (cmp_seq[i]) cmp_seq[i] = vecs[v].cmpv;
      lat  = vecs[v].lat;
      spur = vecs[v].spur;
      run(vecs[v].nm, vecs[v].ops, vecs[v].cyc);
      chk({vecs[v].nm, " end addr"}, bus.uop_addr, vecs[v].end_addr);
    end
    spur = 1'b0;

    // Abort in WAIT of address 3 with flag already set by CMP.
    load_prog(0);
    foreach (cmp_seq[i]) cmp_seq[i] = 1'b1;
    cmp_k = 0;
    lat = 10;
    start_prog();
    c = 0;
    while (!(bus.op_ena && bus.uop_addr == 6'd3) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("abort reached addr3", c < 200, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort rdy", bus.rdy, 1'b1);
    chk("abort op_ena", bus.op_ena, 1'b0);
    chk("abort uop_addr", bus.uop_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    lat = 1;
    load_prog(3);
    run("rerun flag_probe", 1, 9);

    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < 64; a++) begin
        r = $urandom_range(0, 31);
        if (r == 0)      op = 4'($urandom_range(6, 15));
        else if (r == 1) op = OP_RDY;
        else             op = 4'($urandom_range(1, 5));
        rom[a] = {op, 5'($urandom), 5'($urandom), 4'($urandom),
                  2'($urandom)};
        cmp_seq[a] = 1'($urandom);
      end
      lat  = $urandom_range(1, 4);
      spur = 1'($urandom);
      run($sformatf("rand%0d", t), -1, -1);
    end
    spur = 1'b0;
    lat = 1;

`ifdef UOP_ENGINE_WATCHDOG_EN
    load_prog(0);
    mute = 1'b1;
    start_prog();
    c = 1;
    while (!bus.rdy && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("wdog cycles", c, 20);
    chk("wdog err", bus.err, 1'b1);
    mute = 1'b0;
    foreach (cmp_seq[i]) cmp_seq[i] = 1'b0;
    run("after wdog", 6, 31);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
